// File: rtl/debounce_bank.sv
// Bank of independent button debouncers: 2-flop synchroniser, symmetric
// debounce window, press/release edge pulses and a one-shot long-press pulse.
module debounce_bank #(
    parameter int CHANNELS   = 4,
    parameter int CTR_BITS   = 19,
    parameter int HOLD_BITS  = 24,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press,
    output logic                any_change
);

    localparam logic [HOLD_BITS-1:0] HOLD_MAX = '1;
    localparam logic [HOLD_BITS-1:0] HOLD_PRE = HOLD_MAX - 1'b1;

    logic [CHANNELS-1:0] norm;
    logic [CHANNELS-1:0] press_next;
    logic [CHANNELS-1:0] release_next;
    logic                any_change_reg;

    // Normalise polarity so that 1 always means "pressed" from here on.
    assign norm = ACTIVE_LOW ? ~btn : btn;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic                 sync0_reg;
            logic                 sync1_reg;
            logic                 state_reg;
            logic [CTR_BITS-1:0]  ctr_reg;
            logic [HOLD_BITS-1:0] hold_reg;
            logic                 press_reg;
            logic                 release_reg;
            logic                 long_reg;
            logic                 flip;

            // The window completes on the edge where a full counter still sees a difference.
            assign flip             = (sync1_reg != state_reg) && (ctr_reg == '1);
            assign press_next[gi]   = flip && !state_reg;
            assign release_next[gi] = flip && state_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync0_reg   <= 1'b0;
                    sync1_reg   <= 1'b0;
                    state_reg   <= 1'b0;
                    ctr_reg     <= '0;
                    hold_reg    <= '0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    long_reg    <= 1'b0;
                end else begin
                    sync0_reg   <= norm[gi];
                    sync1_reg   <= sync0_reg;
                    press_reg   <= press_next[gi];
                    release_reg <= release_next[gi];

                    if (sync1_reg == state_reg) begin
                        ctr_reg <= '0;
                    end else if (ctr_reg == '1) begin
                        ctr_reg   <= '0;
                        state_reg <= ~state_reg;
                    end else begin
                        ctr_reg <= ctr_reg + 1'b1;
                    end

                    // A release on this edge wins over a simultaneous saturation.
                    long_reg <= 1'b0;
                    if (!state_reg || release_next[gi]) begin
                        hold_reg <= '0;
                    end else if (hold_reg != HOLD_MAX) begin
                        hold_reg <= hold_reg + 1'b1;
                        long_reg <= (hold_reg == HOLD_PRE);
                    end
                end
            end

            assign state[gi]         = state_reg;
            assign press[gi]         = press_reg;
            assign release_pulse[gi] = release_reg;
            assign long_press[gi]    = long_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_change_reg <= 1'b0;
        end else begin
            any_change_reg <= |(press_next | release_next);
        end
    end

    assign any_change = any_change_reg;

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised bench for debounce_bank: an active-high and an active-low instance
// see the same normalised stimulus and are both checked against a window model.
module tb_debounce_bank;

    localparam int CH      = 2;
    localparam int CB      = 3;
    localparam int HB      = 4;
    localparam int WIN     = 8;
    localparam int HOLD_TH = 15;
    localparam int MAXE    = 4096;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] btn;
    logic [CH-1:0] btn_al;

    logic [CH-1:0] st0, pr0, rl0, lp0;
    logic          ac0;
    logic [CH-1:0] st1, pr1, rl1, lp1;
    logic          ac1;

    debounce_bank #(
        .CHANNELS(CH), .CTR_BITS(CB), .HOLD_BITS(HB), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .state(st0), .press(pr0), .release_pulse(rl0),
        .long_press(lp0), .any_change(ac0)
    );

    debounce_bank #(
        .CHANNELS(CH), .CTR_BITS(CB), .HOLD_BITS(HB), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn(btn_al),
        .state(st1), .press(pr1), .release_pulse(rl1),
        .long_press(lp1), .any_change(ac1)
    );

    always #5 clk = ~clk;

    int   t;
    int   n_compared;
    int   n_mismatched;
    int   last_reset;
    logic [CH-1:0] in_hist [MAXE];

    // Reference model: state changes only after a full window of differing samples
    logic m_state [CH];
    int   last_chg [CH];
    int   press_t [CH];
    logic e_press [CH];
    logic e_rel [CH];
    logic e_long [CH];
    logic e_any;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s at edge %0d: got %b expected %b", tag, t, got, exp);
        end
    endtask

    // Synchronised sample the debouncer compares on edge k.
    function automatic logic seen(int ch, int k);
        if (k - 2 <= last_reset) return 1'b0;
        return in_hist[k-2][ch];
    endfunction

    task automatic model_edge(input logic r);
        logic ok;
        e_any = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            e_press[ch] = 1'b0;
            e_rel[ch]   = 1'b0;
            e_long[ch]  = 1'b0;
            if (!r) begin
                m_state[ch]  = 1'b0;
                last_chg[ch] = t;
                press_t[ch]  = -1;
            end else begin
                ok = (t - last_chg[ch] >= WIN);
                for (int k = t - WIN + 1; k <= t; k++)
                    if (ok && seen(ch, k) == m_state[ch]) ok = 1'b0;
                if (ok) begin
                    m_state[ch]  = ~m_state[ch];
                    last_chg[ch] = t;
                    if (m_state[ch]) begin
                        e_press[ch] = 1'b1;
                        press_t[ch] = t;
                    end else begin
                        e_rel[ch]   = 1'b1;
                        press_t[ch] = -1;
                    end
                end
                if (m_state[ch] && press_t[ch] >= 0 && t == press_t[ch] + HOLD_TH)
                    e_long[ch] = 1'b1;
                e_any = e_any | e_press[ch] | e_rel[ch];
            end
        end
        if (!r) last_reset = t;
    endtask

    task automatic run_edge(input logic [CH-1:0] b, input logic r);
        @(negedge clk);
        btn       = b;
        btn_al    = ~b;
        rst_n     = r;
        in_hist[t] = b;
        @(posedge clk);
        model_edge(r);
        #1;
        for (int ch = 0; ch < CH; ch++) begin
            check_eq($sformatf("state[%0d]", ch),         st0[ch], m_state[ch]);
            check_eq($sformatf("press[%0d]", ch),         pr0[ch], e_press[ch]);
            check_eq($sformatf("release[%0d]", ch),       rl0[ch], e_rel[ch]);
            check_eq($sformatf("long_press[%0d]", ch),    lp0[ch], e_long[ch]);
            check_eq($sformatf("al_state[%0d]", ch),      st1[ch], m_state[ch]);
            check_eq($sformatf("al_press[%0d]", ch),      pr1[ch], e_press[ch]);
            check_eq($sformatf("al_release[%0d]", ch),    rl1[ch], e_rel[ch]);
            check_eq($sformatf("al_long_press[%0d]", ch), lp1[ch], e_long[ch]);
        end
        check_eq("any_change",    ac0, e_any);
        check_eq("al_any_change", ac1, e_any);
        t++;
    endtask

    task automatic hold_for(input logic [CH-1:0] b, input int n);
        for (int i = 0; i < n; i++) run_edge(b, 1'b1);
    endtask

    initial begin
        int seg;
        logic [CH-1:0] b;
        clk          = 1'b0;
        btn          = '0;
        btn_al       = '1;
        rst_n        = 1'b0;
        t            = 1;
        n_compared   = 0;
        n_mismatched = 0;
        last_reset   = 0;
        for (int ch = 0; ch < CH; ch++) begin
            m_state[ch]  = 1'b0;
            last_chg[ch] = 0;
            press_t[ch]  = -1;
        end

        $display("reset: 3 edges");
        for (int i = 0; i < 3; i++) run_edge(2'b00, 1'b0);

        $display("single press, long press, release");
        hold_for(2'b01, 30);
        hold_for(2'b00, 15);

        $display("short glitch on channel 0");
        hold_for(2'b01, 5);
        hold_for(2'b00, 12);

        $display("both channels pressed together");
        hold_for(2'b11, 14);
        hold_for(2'b00, 14);

        $display("reset mid-window with channel 0 held");
        hold_for(2'b01, 7);
        run_edge(2'b01, 1'b0);
        hold_for(2'b01, 20);
        hold_for(2'b00, 14);

        $display("randomised segments with occasional reset");
        while (t < 3000) begin
            seg = $urandom_range(1, 40);
            b   = CH'($urandom_range(0, 3));
            for (int i = 0; i < seg; i++)
                run_edge(b, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
